// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage types and defaults: state encoding, word/address widths
// and the reset/NOP constants also used by the IF/ID and ID/EX buffers.
package if_fetch_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam addr_t RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_RESET,
        S_REQ,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

    // Word-addressed PC: sequential fetch wraps modulo 2^32.
    function automatic addr_t pc_inc(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/if_fetch_fsm.sv
// Fetch control FSM: tracks the single outstanding instruction-memory request
// and decides when to hold a captured word or drain an abandoned request.
module if_fetch_fsm
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         redirect,
    input  logic         imem_ack,
    output fetch_state_t state,
    output logic         imem_req
);

    fetch_state_t state_reg;
    fetch_state_t state_next;

    assign state = state_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        case (state_reg)
            S_RESET: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // An unanswered request must be drained before refetching.
                    state_next = imem_ack ? S_REQ : S_DRAIN;
                end else if (stall && imem_ack) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_RESET;
            end
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, the stall hold register and the
// instr/pc/pc_plus1/valid outputs that feed the IF/ID buffer.
module if_fetch_stage
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [WORD_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus1_out,
    output logic              valid_out
);

    fetch_state_t state;

    addr_t fetch_pc_reg;
    word_t hold_instr_reg;
    addr_t hold_pc_reg;
    word_t instr_reg;
    addr_t pc_reg;
    addr_t pc_plus1_reg;
    logic  valid_reg;

    logic  capture;

    if_fetch_fsm u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .redirect (redirect),
        .imem_ack (imem_ack),
        .state    (state),
        .imem_req (imem_req)
    );

    // Acks are only meaningful while a live request is on the bus.
    assign capture   = (state == S_REQ) && imem_ack;
    assign imem_addr = fetch_pc_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            valid_reg    <= 1'b0;
            instr_reg    <= NOP_INSTR;
            pc_reg       <= '0;
            pc_plus1_reg <= '0;
        end else if (state == S_RESET) begin
            if (redirect) begin
                fetch_pc_reg <= redirect_pc;
            end
        end else if (redirect) begin
            fetch_pc_reg <= redirect_pc;
            valid_reg    <= 1'b0;
            instr_reg    <= NOP_INSTR;
        end else if (stall) begin
            if (capture) begin
                hold_instr_reg <= imem_rdata;
                hold_pc_reg    <= fetch_pc_reg;
                fetch_pc_reg   <= pc_inc(fetch_pc_reg);
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (capture) begin
                        valid_reg    <= 1'b1;
                        instr_reg    <= imem_rdata;
                        pc_reg       <= fetch_pc_reg;
                        pc_plus1_reg <= pc_inc(fetch_pc_reg);
                        fetch_pc_reg <= pc_inc(fetch_pc_reg);
                    end else begin
                        valid_reg <= 1'b0;
                        instr_reg <= NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    // fetch_pc was already advanced when the word was captured.
                    valid_reg    <= 1'b1;
                    instr_reg    <= hold_instr_reg;
                    pc_reg       <= hold_pc_reg;
                    pc_plus1_reg <= pc_inc(hold_pc_reg);
                end
                default: begin
                    valid_reg <= 1'b0;
                    instr_reg <= NOP_INSTR;
                end
            endcase
        end
    end

    assign valid_out    = valid_reg;
    assign instr_out    = instr_reg;
    assign pc_out       = pc_reg;
    assign pc_plus1_out = pc_plus1_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed scenarios push expected
// fetches into a queue, a negedge monitor pops them as the stage delivers.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr_out, pc_out, pc_plus1_out;
    logic        valid_out;

    logic        rst_w;
    logic        req_w;
    logic [31:0] addr_w, instr_w, pc_w, pc1_w;
    logic        valid_w;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb_q[$];

    int          lat = 0;
    int          acks_limit = 0;
    int          acks_done;
    int          cnt;
    logic        pending;
    logic [31:0] paddr;
    logic        model_ack, inject_ack;
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instr_out(instr_out),
        .pc_out(pc_out), .pc_plus1_out(pc_plus1_out), .valid_out(valid_out)
    );

    // Second instance with an all-ones reset PC and an always-ready memory.
    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFF), .NOP_INSTR(NOP)) dut_w (
        .clk(clk), .rst_n(rst_w), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_req(req_w), .imem_addr(addr_w),
        .imem_rdata(memw(addr_w)), .imem_ack(req_w), .instr_out(instr_w),
        .pc_out(pc_w), .pc_plus1_out(pc1_w), .valid_out(valid_w)
    );

    // Memory model: lat=0 answers combinationally, otherwise latches the
    // request and answers lat cycles later; acks_limit caps total answers.
    always_comb begin
        model_ack   = 1'b0;
        model_rdata = 32'h0;
        if (acks_done < acks_limit) begin
            if (pending && cnt >= lat) begin
                model_ack   = 1'b1;
                model_rdata = memw(paddr);
            end else if (!pending && imem_req && lat == 0) begin
                model_ack   = 1'b1;
                model_rdata = memw(imem_addr);
            end
        end
        imem_ack   = model_ack | inject_ack;
        imem_rdata = inject_ack ? 32'hDEAD_BEEF : model_rdata;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            cnt       <= 0;
            acks_done <= 0;
            paddr     <= 32'h0;
        end else if (model_ack) begin
            acks_done <= acks_done + 1;
            pending   <= 1'b0;
        end else if (pending) begin
            cnt <= cnt + 1;
        end else if (imem_req && lat > 0 && acks_done < acks_limit) begin
            pending <= 1'b1;
            paddr   <= imem_addr;
            cnt     <= 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid_out && !stall) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_instr: got pc=%08h instr=%08h expected none", pc_out, instr_out);
            end else begin
                e = sb_q.pop_front();
                n_vec++;
                if (instr_out !== e.instr || pc_out !== e.pc || pc_plus1_out !== e.pc1) begin
                    n_err++;
                    $display("FAIL fetch: got pc=%08h pc1=%08h instr=%08h expected pc=%08h pc1=%08h instr=%08h",
                             pc_out, pc_plus1_out, instr_out, e.pc, e.pc1, e.instr);
                end else begin
                    $display("txn pc=%08h pc1=%08h instr=%08h ok", pc_out, pc_plus1_out, instr_out);
                end
            end
        end
        if (rst_n && prev_wait && imem_req) check("addr_stable", imem_addr, prev_addr);
        prev_wait = rst_n && imem_req && !imem_ack;
        prev_addr = imem_addr;
    end

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.instr = memw(pc);
        e.pc    = pc;
        e.pc1   = pc + 32'd1;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset(input int l, input int limit);
        @(posedge clk);
        #1;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; inject_ack = 1'b0;
        lat = l; acks_limit = limit;
        idle(2);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 300 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb_q.size());
            sb_q.delete();
        end
        #1;
    endtask

    task automatic check_bubble(input string name);
        check({name, "_valid"}, {31'h0, valid_out}, 32'h0);
        check({name, "_instr"}, instr_out, NOP);
    endtask

    initial begin
        int pat[9] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        inject_ack = 1'b0; rst_w = 1'b0;

        // Reset values and zero-wait throughput.
        apply_reset(0, 4);
        @(negedge clk);
        check_bubble("rst");
        check("rst_pc", pc_out, 32'h0);
        check("rst_pc1", pc_plus1_out, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        for (int p = 0; p < 4; p++) push(p);
        release_reset();
        wait_drain("zero_wait");
        idle(2);
        check_bubble("zw_after");
        check("zw_next_addr", imem_addr, 32'd4);

        // Two-cycle memory: valid every other cycle.
        apply_reset(1, 3);
        for (int p = 0; p < 3; p++) push(p);
        release_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("lat_valid%0d", k), {31'h0, valid_out}, pat[k]);
        end
        wait_drain("lat");
        check("lat_pc_hold", pc_out, 32'd2);

        // Stall while the ack for pc 5 returns.
        apply_reset(0, 5);
        for (int p = 0; p < 5; p++) push(p);
        release_reset();
        wait_drain("stall_pre");
        idle(2);
        stall = 1'b1; acks_limit = 6;
        for (int k = 0; k < 2; k++) begin
            idle(1);
            @(negedge clk);
            check("hold_req", {31'h0, imem_req}, 32'h0);
            check("hold_valid", {31'h0, valid_out}, 32'h0);
            check("hold_pc", pc_out, 32'd4);
            check("hold_pc1", pc_plus1_out, 32'd5);
        end
        push(5);
        idle(1);
        stall = 1'b0;
        idle(1);
        @(negedge clk);
        check("hold_valid_out", {31'h0, valid_out}, 32'h1);
        check("hold_next_req", {31'h0, imem_req}, 32'h1);
        check("hold_next_addr", imem_addr, 32'd6);
        wait_drain("stall");

        // Redirect while the request for pc 7 is still outstanding.
        apply_reset(0, 7);
        for (int p = 0; p < 7; p++) push(p);
        release_reset();
        wait_drain("redir_pre");
        idle(1);
        lat = 3; acks_limit = 9;
        idle(1);
        redirect = 1'b1; redirect_pc = 32'h40;
        idle(1);
        redirect = 1'b0;
        @(negedge clk);
        check_bubble("redir");
        check("drain_req", {31'h0, imem_req}, 32'h0);
        push(32'h40);
        wait_drain("redir");
        check("redir_pc", pc_out, 32'h40);

        // Redirect together with stall while pc 9 is held.
        apply_reset(0, 11);
        for (int p = 0; p < 8; p++) push(p);
        release_reset();
        idle(10);
        stall = 1'b1;
        idle(1);
        redirect = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        check("rs_hold_req", {31'h0, imem_req}, 32'h0);
        idle(1);
        stall = 1'b0; redirect = 1'b0;
        @(negedge clk);
        check_bubble("rs");
        push(32'h80);
        wait_drain("redir_stall");

        // PC wrap from 32'hFFFF_FFFF on the second instance.
        @(negedge clk);
        check("wrap_rst_valid", {31'h0, valid_w}, 32'h0);
        @(posedge clk);
        #1;
        rst_w = 1'b1;
        idle(2);
        @(negedge clk);
        check("wrap_pc0", pc_w, 32'hFFFF_FFFF);
        check("wrap_pc1_0", pc1_w, 32'h0);
        check("wrap_instr0", instr_w, memw(32'hFFFF_FFFF));
        @(negedge clk);
        check("wrap_pc1", pc_w, 32'h0);
        check("wrap_pc1_1", pc1_w, 32'h1);
        check("wrap_valid", {31'h0, valid_w}, 32'h1);

        // Reset mid-request, then a stale ack while in reset state.
        apply_reset(0, 3);
        for (int p = 0; p < 3; p++) push(p);
        release_reset();
        wait_drain("mid_pre");
        idle(1);
        check("mid_pc_before", pc_out, 32'd2);
        lat = 3; acks_limit = 10;
        idle(1);
        rst_n = 1'b0;
        idle(1);
        @(negedge clk);
        check_bubble("mid_rst");
        check("mid_rst_pc", pc_out, 32'h0);
        check("mid_rst_pc1", pc_plus1_out, 32'h0);
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        push(0);
        push(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1; inject_ack = 1'b1; lat = 0; acks_limit = 2;
        idle(1);
        inject_ack = 1'b0;
        wait_drain("mid");
        idle(3);
        check_bubble("mid_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
